// File: rtl/tdc_fifo_rr_scheduler_pkg.sv
// Shared TDC scheduler types: arbitration state encoding and channel-id width helper.
// Pure declarations; no logic, no latency, no flow control.
package tdc_fifo_rr_scheduler_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } sched_state_t;

    // Width of an index into n items; a single item still needs one bit.
    function automatic int chan_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdc_fifo_rr_scheduler_rr_pick.sv
// Rotating-priority search: first set request at or above ptr, wrapping around.
// Purely combinational (0 cycles); no backpressure.
module tdc_rr_pick
    import tdc_fifo_rr_scheduler_pkg::*;
#(
    parameter int TDC_COUNT = 8,
    localparam int CW = chan_id_w(TDC_COUNT)
) (
    input  logic [TDC_COUNT-1:0] request,
    input  logic [CW-1:0]        ptr,
    output logic                 any,
    output logic [CW-1:0]        index
);

    always_comb begin
        any   = 1'b0;
        index = '0;
        for (int off = 0; off < TDC_COUNT; off++) begin
            if (!any && request[CW'((int'(ptr) + off) % TDC_COUNT)]) begin
                any   = 1'b1;
                index = CW'((int'(ptr) + off) % TDC_COUNT);
            end
        end
    end

endmodule

// File: rtl/tdc_fifo_rr_scheduler.sv
// Round-robin burst reader draining per-channel TDC FWFT FIFOs into one registered word stream.
// Read one cycle after grant, dout_valid one cycle after read; a stalled dout holds and blocks reads.
module tdc_fifo_rr_scheduler
    import tdc_fifo_rr_scheduler_pkg::*;
#(
    parameter int TDC_COUNT      = 8,
    parameter int TDC_DATA_WIDTH = 40,
    parameter int MAX_BURST      = 16,
    localparam int CW = chan_id_w(TDC_COUNT),
    localparam int BW = chan_id_w(MAX_BURST + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [TDC_COUNT-1:0]                locked,
    input  logic [TDC_COUNT-1:0]                tdc_fifo_empty,
    input  logic [TDC_COUNT*TDC_DATA_WIDTH-1:0] tdc_fifo_data,
    output logic [TDC_COUNT-1:0]                tdc_fifo_read,
    output logic [TDC_DATA_WIDTH-1:0]           dout,
    output logic [CW-1:0]                       dout_channel,
    output logic                                dout_valid,
    input  logic                                dout_ready
);

    sched_state_t   state, state_nxt;
    logic [CW-1:0]  rr_ptr;
    logic [CW-1:0]  grant;
    logic [BW-1:0]  burst_cnt;

    logic [TDC_COUNT-1:0] readable;
    logic                 pick_any;
    logic [CW-1:0]        pick_idx;
    logic                 load;
    logic                 grant_rdbl;
    logic                 rd;
    logic                 burst_done;
    logic [CW-1:0]        next_ptr;

    assign readable   = locked & ~tdc_fifo_empty;
    assign load       = !dout_valid || dout_ready;
    assign grant_rdbl = readable[grant];
    assign next_ptr   = (grant == CW'(TDC_COUNT - 1)) ? '0 : grant + 1'b1;

    tdc_rr_pick #(
        .TDC_COUNT (TDC_COUNT)
    ) u_pick (
        .request (readable),
        .ptr     (rr_ptr),
        .any     (pick_any),
        .index   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rd            = 1'b0;
        burst_done    = 1'b0;
        tdc_fifo_read = '0;
        case (state)
            ST_IDLE: begin
                if (enable && pick_any) begin
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                // Losing enable or the channel ends the burst without a read.
                if (!enable || !grant_rdbl) begin
                    state_nxt  = ST_IDLE;
                    burst_done = 1'b1;
                end else if (load) begin
                    rd = !rst;
                    if (burst_cnt == BW'(MAX_BURST - 1)) begin
                        state_nxt  = ST_IDLE;
                        burst_done = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        tdc_fifo_read = rd ? (TDC_COUNT'(1) << grant) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant     <= '0;
            burst_cnt <= '0;
        end else begin
            if (state == ST_IDLE && state_nxt == ST_BURST) begin
                grant     <= pick_idx;
                burst_cnt <= '0;
            end else if (rd) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (burst_done) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout         <= '0;
            dout_channel <= '0;
            dout_valid   <= 1'b0;
        end else if (rd) begin
            dout         <= tdc_fifo_data[int'(grant)*TDC_DATA_WIDTH +: TDC_DATA_WIDTH];
            dout_channel <= grant;
            dout_valid   <= 1'b1;
        end else if (load) begin
            dout_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tdc_fifo_rr_scheduler.sv
// Directed bench for the TDC round-robin scheduler with behavioural FWFT FIFOs.
// Each FIFO word is {channel, sequence number}, so order, loss and duplication are visible.
module tb_tdc_fifo_rr_scheduler;
    import tdc_fifo_rr_scheduler_pkg::*;

    localparam int N  = 8;
    localparam int W  = 40;
    localparam int MB = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [N-1:0]   locked;
    logic [N-1:0]   tdc_fifo_empty;
    logic [N*W-1:0] tdc_fifo_data;
    logic [N-1:0]   tdc_fifo_read;
    logic [W-1:0]   dout;
    logic [2:0]     dout_channel;
    logic           dout_valid;
    logic           dout_ready;

    always #5 clk = ~clk;

    tdc_fifo_rr_scheduler #(
        .TDC_COUNT      (N),
        .TDC_DATA_WIDTH (W),
        .MAX_BURST      (MB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .locked         (locked),
        .tdc_fifo_empty (tdc_fifo_empty),
        .tdc_fifo_data  (tdc_fifo_data),
        .tdc_fifo_read  (tdc_fifo_read),
        .dout           (dout),
        .dout_channel   (dout_channel),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready)
    );

    logic [31:0] pushed [N] = '{default: '0};
    logic [31:0] popped [N] = '{default: '0};

    always_comb begin
        for (int i = 0; i < N; i++) begin
            tdc_fifo_empty[i]      = (pushed[i] == popped[i]);
            tdc_fifo_data[i*W +: W] = {8'(i), popped[i]};
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (tdc_fifo_read[i]) popped[i] <= popped[i] + 1;
        end
    end

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          rd_log[$];
    int          rd_cyc[$];
    int          acc_log[$];
    logic [31:0] exp_seq [N];

    typedef struct {
        logic [7:0] lck;
        logic [7:0] ne;
        logic       any;
        int         ch;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: observe strobes and handshakes at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (tdc_fifo_read != '0) begin
            check("rd_legal", 64'($onehot(tdc_fifo_read) &&
                  ((tdc_fifo_read & ~(locked & ~tdc_fifo_empty)) == '0)), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (tdc_fifo_read[i]) begin
                    rd_log.push_back(i);
                    rd_cyc.push_back(cyc);
                end
            end
        end
        if (!rst && dout_valid && dout_ready) begin
            check("acc_data", 64'(dout), 64'({8'(dout_channel), exp_seq[dout_channel]}));
            exp_seq[dout_channel] = exp_seq[dout_channel] + 1;
            acc_log.push_back(int'(dout_channel));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input int ch, input int n);
        pushed[ch] = pushed[ch] + 32'(n);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        enable     = 1'b0;
        dout_ready = 1'b1;
        locked     = '1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            pushed[i]  = popped[i];
            exp_seq[i] = popped[i];
        end
        rd_log.delete();
        rd_cyc.delete();
        acc_log.delete();
    endtask

    task automatic wait_reads(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (rd_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, 64'(rd_log.size() >= n), 64'd1);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int          exp_q[$];
        int          rem[N];
        int          run, maxrun, d, k;
        logic [7:0]  e;
        logic [W-1:0] snap;

        vecs[0] = '{lck: 8'hFF, ne: 8'h08, any: 1'b1, ch: 3};
        vecs[1] = '{lck: 8'hFF, ne: 8'hA0, any: 1'b1, ch: 5};
        vecs[2] = '{lck: 8'hF0, ne: 8'h0F, any: 1'b0, ch: 0};
        vecs[3] = '{lck: 8'h0C, ne: 8'hFF, any: 1'b1, ch: 2};
        vecs[4] = '{lck: 8'hFF, ne: 8'h81, any: 1'b1, ch: 0};
        vecs[5] = '{lck: 8'hBF, ne: 8'h40, any: 1'b0, ch: 0};

        // Reset state, with a readable channel present and enable high.
        rst = 1'b1; enable = 1'b1; locked = '1; dout_ready = 1'b1;
        for (int i = 0; i < N; i++) exp_seq[i] = '0;
        push(0, 1);
        ticks(2);
        check("rst_read",   64'(tdc_fifo_read), 64'd0);
        check("rst_valid",  64'(dout_valid), 64'd0);
        check("rst_dout",   64'(dout), 64'd0);
        check("rst_chan",   64'(dout_channel), 64'd0);
        check("rst_state",  64'(dut.state), 64'(ST_IDLE));
        check("rst_rrptr",  64'(dut.rr_ptr), 64'd0);
        check("rst_grant",  64'(dut.grant), 64'd0);
        check("rst_bcnt",   64'(dut.burst_cnt), 64'd0);

        // First grant from rr_ptr=0: read at t+1, dout_valid at t+2.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            locked = vecs[v].lck;
            for (int i = 0; i < N; i++) if (vecs[v].ne[i]) push(i, 1);
            enable = 1'b1;
            tick();
            e = vecs[v].any ? (8'd1 << vecs[v].ch) : 8'd0;
            check("vec_read", 64'(tdc_fifo_read), 64'(e));
            tick();
            check("vec_valid", 64'(dout_valid), 64'(vecs[v].any));
            if (vecs[v].any) check("vec_chan", 64'(dout_channel), 64'(vecs[v].ch));
        end

        // Channel 3 with 5 words: back-to-back reads, then IDLE with rr_ptr=4.
        do_reset();
        push(3, 5);
        enable = 1'b1;
        wait_reads(5, 20, "A_reads");
        for (int i = 0; i < rd_log.size(); i++) begin
            check("A_rd_chan", 64'(rd_log[i]), 64'd3);
            check("A_rd_cyc",  64'(rd_cyc[i]), 64'(rd_cyc[0] + i));
        end
        ticks(3);
        check("A_acc_cnt", 64'(acc_log.size()), 64'd5);
        foreach (acc_log[i]) check("A_acc_chan", 64'(acc_log[i]), 64'd3);
        check("A_state", 64'(dut.state), 64'(ST_IDLE));
        check("A_rrptr", 64'(dut.rr_ptr), 64'd4);

        // All channels 40 words: bursts of 16, 16, then 8 in channel order.
        do_reset();
        for (int i = 0; i < N; i++) begin
            push(i, 40);
            rem[i] = 40;
        end
        enable = 1'b1;
        wait_reads(320, 1200, "B_reads");
        ticks(4);
        while (rem[0] + rem[1] + rem[2] + rem[3] + rem[4] + rem[5] + rem[6] + rem[7] > 0) begin
            for (int c = 0; c < N; c++) begin
                d = (rem[c] < MB) ? rem[c] : MB;
                for (int j = 0; j < d; j++) exp_q.push_back(c);
                rem[c] -= d;
            end
        end
        for (int i = 0; i < rd_log.size() && i < exp_q.size(); i++)
            check("B_order", 64'(rd_log[i]), 64'(exp_q[i]));
        check("B_acc_cnt", 64'(acc_log.size()), 64'd320);
        run = 0; maxrun = 0;
        for (int i = 0; i < acc_log.size(); i++) begin
            run = (i > 0 && acc_log[i] == acc_log[i-1]) ? run + 1 : 1;
            if (run > maxrun) maxrun = run;
        end
        check("B_maxrun", 64'(maxrun), 64'(MB));

        // Backpressure for 4 cycles mid-burst on channel 1.
        do_reset();
        push(1, 10);
        enable = 1'b1;
        ticks(4);
        check("C_valid_pre", 64'(dout_valid), 64'd1);
        dout_ready = 1'b0;
        #1;
        snap = dout;
        for (int s = 0; s < 4; s++) begin
            check("C_stall_read",  64'(tdc_fifo_read), 64'd0);
            check("C_stall_dout",  64'(dout), 64'(snap));
            check("C_stall_valid", 64'(dout_valid), 64'd1);
            tick();
        end
        dout_ready = 1'b1;
        wait_reads(10, 40, "C_reads");
        ticks(3);
        check("C_acc_cnt", 64'(acc_log.size()), 64'd10);
        check("C_rd_cnt",  64'(rd_log.size()), 64'd10);

        // Channel 2 loses lock mid-burst.
        do_reset();
        push(2, 10);
        push(3, 10);
        enable = 1'b1;
        wait_reads(3, 10, "D_pre");
        locked[2] = 1'b0;
        #1;
        check("D_drop_read", 64'(tdc_fifo_read), 64'd0);
        tick();
        check("D_state", 64'(dut.state), 64'(ST_IDLE));
        check("D_rrptr", 64'(dut.rr_ptr), 64'd3);
        d = rd_log.size();
        wait_reads(d + 10, 40, "D_reads");
        ticks(4);
        if (rd_log.size() > d) check("D_next_chan", 64'(rd_log[d]), 64'd3);
        for (int i = d; i < rd_log.size(); i++) check("D_no_ch2", 64'(rd_log[i] == 2), 64'd0);
        locked = '1;

        // Reset mid-burst with a word waiting in dout.
        do_reset();
        push(2, 1);
        enable = 1'b1;
        wait_reads(1, 10, "E_pre");
        ticks(3);
        check("E_rrptr_pre", 64'(dut.rr_ptr), 64'd3);
        push(5, 10);
        dout_ready = 1'b0;
        k = 0;
        while (!dout_valid && k < 10) begin
            tick();
            k++;
        end
        check("E_valid_pre", 64'(dout_valid), 64'd1);
        check("E_state_pre", 64'(dut.state), 64'(ST_BURST));
        rst = 1'b1;
        dout_ready = 1'b1;
        #1;
        check("E_rst_read", 64'(tdc_fifo_read), 64'd0);
        tick();
        check("E_valid",  64'(dout_valid), 64'd0);
        check("E_read",   64'(tdc_fifo_read), 64'd0);
        check("E_rrptr",  64'(dut.rr_ptr), 64'd0);
        check("E_dout",   64'(dout), 64'd0);
        rst = 1'b0;

        // Wrap-around search from rr_ptr=7.
        do_reset();
        push(6, 1);
        enable = 1'b1;
        wait_reads(1, 10, "F_pre");
        ticks(3);
        check("F_rrptr7", 64'(dut.rr_ptr), 64'd7);
        push(7, 1);
        tick();
        check("F_grant7", 64'(dut.grant), 64'd7);
        wait_reads(2, 10, "F_rd7");
        if (rd_log.size() > 1) check("F_rd7_chan", 64'(rd_log[1]), 64'd7);
        ticks(3);
        check("F_rrptr0", 64'(dut.rr_ptr), 64'd0);
        push(6, 1);
        wait_reads(3, 10, "F_rd6");
        ticks(3);
        check("F_rrptr7b", 64'(dut.rr_ptr), 64'd7);
        push(0, 1);
        push(5, 1);
        tick();
        check("F_grant0", 64'(dut.grant), 64'd0);
        wait_reads(4, 10, "F_rd0");
        if (rd_log.size() > 3) check("F_rd0_chan", 64'(rd_log[3]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
